// File: rtl/stage3_sequencer.sv
// Stage-3 execute sequencer: turns one decoded execute command into ALU/Res
// control over one or more EXEC cycles, followed by a single DONE cycle.
module stage3_sequencer (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       Start,
    input  logic [1:0] Class,
    input  logic [3:0] Funct,
    input  logic [3:0] Count,
    input  logic       Cond,
    input  logic       IsZero,
    input  logic       Stall,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] ALUop,
    output logic       ResSource,
    output logic       ResWrite,
    output logic       ALUASel,
    output logic       BranchTaken
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] C_ALU    = 2'd0;
    localparam logic [1:0] C_SHIFT  = 2'd1;
    localparam logic [1:0] C_BRANCH = 2'd2;
    localparam logic [1:0] C_REPEAT = 2'd3;

    state_t     state;
    logic [1:0] cls;
    logic [3:0] funct;
    logic [3:0] cnt;
    logic       cond;
    logic       first;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            cls         <= C_ALU;
            funct       <= 4'd0;
            cnt         <= 4'd0;
            cond        <= 1'b0;
            first       <= 1'b0;
            BranchTaken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        cls         <= Class;
                        funct       <= Funct;
                        cnt         <= Count;
                        cond        <= Cond;
                        first       <= 1'b1;
                        BranchTaken <= 1'b0;
                        state       <= (Class == C_REPEAT && Count == 4'd0) ? DONE : EXEC;
                    end
                end
                EXEC: begin
                    if (!Stall) begin
                        first <= 1'b0;
                        if (cls == C_REPEAT) begin
                            cnt <= cnt - 4'd1;
                            // counter at 1 marks the final iteration
                            if (cnt <= 4'd1)
                                state <= DONE;
                        end else begin
                            state <= DONE;
                        end
                        if (cls == C_BRANCH)
                            BranchTaken <= IsZero ^ cond;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Control decode from state and latched command; only ResWrite sees Stall.
    always_comb begin
        Busy      = (state != IDLE);
        Done      = (state == DONE);
        ALUop     = 4'd0;
        ResSource = 1'b0;
        ResWrite  = 1'b0;
        ALUASel   = 1'b0;
        if (state == EXEC) begin
            ALUop     = funct;
            ResSource = (cls == C_SHIFT);
            ResWrite  = (cls != C_BRANCH) && !Stall;
            ALUASel   = (cls == C_REPEAT) && !first;
        end
    end

endmodule

// File: tb/tb_stage3_sequencer.sv
// Self-checking bench for stage3_sequencer: directed plan items plus random
// commands, each predicted cycle by cycle from iteration counts and stall pattern.
module tb_stage3_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       Start;
    logic [1:0] Class;
    logic [3:0] Funct;
    logic [3:0] Count;
    logic       Cond;
    logic       IsZero;
    logic       Stall;
    logic       Busy;
    logic       Done;
    logic [3:0] ALUop;
    logic       ResSource;
    logic       ResWrite;
    logic       ALUASel;
    logic       BranchTaken;

    int checks = 0;
    int errors = 0;
    logic bt_exp = 1'b0;

    always #5 CLK = ~CLK;

    stage3_sequencer dut (
        .CLK(CLK), .nRST(nRST), .Start(Start), .Class(Class), .Funct(Funct),
        .Count(Count), .Cond(Cond), .IsZero(IsZero), .Stall(Stall),
        .Busy(Busy), .Done(Done), .ALUop(ALUop), .ResSource(ResSource),
        .ResWrite(ResWrite), .ALUASel(ALUASel), .BranchTaken(BranchTaken)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, {3'd0, Busy}, 4'd0);
        chk({tag, ".done"}, {3'd0, Done}, 4'd0);
        chk({tag, ".aluop"}, ALUop, 4'd0);
        chk({tag, ".ressrc"}, {3'd0, ResSource}, 4'd0);
        chk({tag, ".reswr"}, {3'd0, ResWrite}, 4'd0);
        chk({tag, ".asel"}, {3'd0, ALUASel}, 4'd0);
        chk({tag, ".bt"}, {3'd0, BranchTaken}, 4'd0);
    endtask

    task automatic scramble_cmd_inputs();
        Class = 2'($urandom);
        Funct = 4'($urandom);
        Count = 4'($urandom);
        Cond  = 1'($urandom);
    endtask

    // Issue one command from IDLE and follow it to completion. Bit k of
    // stall_mask is Stall in the k-th EXEC cycle.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [3:0] f,
                           input logic [3:0] n, input logic cd, input logic iz,
                           input logic [31:0] stall_mask);
        int iters;
        int it;
        int cyc;
        logic st;
        @(negedge CLK);
        Start = 1'b1; Class = c; Funct = f; Count = n; Cond = cd;
        IsZero = iz; Stall = 1'($urandom);
        #1;
        chk({tag, ".idle_busy"}, {3'd0, Busy}, 4'd0);
        chk({tag, ".idle_done"}, {3'd0, Done}, 4'd0);
        chk({tag, ".idle_reswr"}, {3'd0, ResWrite}, 4'd0);
        chk({tag, ".idle_bt"}, {3'd0, BranchTaken}, {3'd0, bt_exp});
        @(posedge CLK);
        bt_exp = 1'b0;
        iters = (c == 2'd3) ? int'(n) : 1;
        it = 0;
        cyc = 0;
        while (it < iters) begin
            @(negedge CLK);
            Start = 1'($urandom);
            scramble_cmd_inputs();
            st = (cyc < 32) ? stall_mask[cyc] : 1'b0;
            Stall = st;
            IsZero = iz;
            #1;
            chk({tag, ".ex_busy"}, {3'd0, Busy}, 4'd1);
            chk({tag, ".ex_done"}, {3'd0, Done}, 4'd0);
            chk({tag, ".ex_aluop"}, ALUop, f);
            chk({tag, ".ex_ressrc"}, {3'd0, ResSource}, {3'd0, c == 2'd1});
            chk({tag, ".ex_reswr"}, {3'd0, ResWrite}, {3'd0, (c != 2'd2) && !st});
            chk({tag, ".ex_asel"}, {3'd0, ALUASel}, {3'd0, (c == 2'd3) && (it > 0)});
            chk({tag, ".ex_bt"}, {3'd0, BranchTaken}, 4'd0);
            @(posedge CLK);
            if (!st) it++;
            cyc++;
        end
        if (c == 2'd2) bt_exp = iz ^ cd;
        @(negedge CLK);
        Start = 1'($urandom);
        scramble_cmd_inputs();
        Stall = 1'($urandom);
        #1;
        chk({tag, ".dn_busy"}, {3'd0, Busy}, 4'd1);
        chk({tag, ".dn_done"}, {3'd0, Done}, 4'd1);
        chk({tag, ".dn_reswr"}, {3'd0, ResWrite}, 4'd0);
        chk({tag, ".dn_aluop"}, ALUop, 4'd0);
        chk({tag, ".dn_ressrc"}, {3'd0, ResSource}, 4'd0);
        chk({tag, ".dn_asel"}, {3'd0, ALUASel}, 4'd0);
        chk({tag, ".dn_bt"}, {3'd0, BranchTaken}, {3'd0, bt_exp});
        @(posedge CLK);
    endtask

    initial begin
        nRST = 1'b0; Start = 1'b0; Class = 2'd0; Funct = 4'd0; Count = 4'd0;
        Cond = 1'b0; IsZero = 1'b0; Stall = 1'b0;
        @(negedge CLK);
        #1;
        chk_all_zero("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // Directed plan items
        run_cmd("alu", 2'd0, 4'h3, 4'd0, 1'b0, 1'b0, 32'h0);
        run_cmd("shift_stall", 2'd1, 4'h5, 4'd0, 1'b0, 1'b0, 32'h3);
        run_cmd("br_taken", 2'd2, 4'h1, 4'd0, 1'b0, 1'b1, 32'h0);
        run_cmd("br_not", 2'd2, 4'h2, 4'd0, 1'b1, 1'b1, 32'h0);
        run_cmd("rep3", 2'd3, 4'h9, 4'd3, 1'b0, 1'b0, 32'h0);
        run_cmd("rep0", 2'd3, 4'h7, 4'd0, 1'b0, 1'b0, 32'h0);
        run_cmd("after_rep0", 2'd0, 4'hA, 4'd0, 1'b0, 1'b0, 32'h0);
        run_cmd("rep_stall", 2'd3, 4'hC, 4'd4, 1'b0, 1'b0, 32'h0000_0012);

        // Reset mid-REPEAT 5
        @(negedge CLK);
        Start = 1'b1; Class = 2'd3; Funct = 4'hE; Count = 4'd5; Stall = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        bt_exp = 1'b0;
        run_cmd("post_reset", 2'd0, 4'h3, 4'd0, 1'b0, 1'b0, 32'h0);

        // Randomized commands
        for (int k = 0; k < 60; k++) begin
            logic [31:0] m;
            m = $urandom & $urandom;
            run_cmd("rand", 2'($urandom), 4'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), m);
        end

        @(negedge CLK);
        Start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so a stuck design still ends the run
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
